// File: rtl/sharp_mlcd_line_writer.sv
// sharp_mlcd_line_writer
//   Multi-line Sharp memory-LCD writer. Takes static / update / all-clear
//   commands over a valid/ready port, pulls pixel bytes from a stallable
//   valid/ready source and serialises the frame on SCS/SCLK/SI. The VCOM
//   (M1) bit flips after every completed frame.
//
// Ports
//   clk_12mhz, rst        system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0 static, 1 update, 2 all clear, 3 reserved
//   cmd_first_line        first gate address, 1-based
//   cmd_line_count        number of consecutive lines to update
//   pix_valid/pix_ready   pixel byte handshake, pix_data[7] = leftmost pixel
//   busy                  frame (or reject) in progress
//   cmd_err               one-cycle pulse after a rejected command
//   SCLK, SI, SCS         panel serial interface
module sharp_mlcd_line_writer #(
    parameter int unsigned CLK_DIV     = 12,
    parameter int unsigned LINE_PIXELS = 144,
    parameter int unsigned NUM_LINES   = 168,
    parameter int unsigned SETUP_BITS  = 8,
    parameter int unsigned HOLD_BITS   = 4
) (
    input  logic       clk_12mhz,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_first_line,
    input  logic [7:0] cmd_line_count,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    output logic       busy,
    output logic       cmd_err,
    output logic       SCLK,
    output logic       SI,
    output logic       SCS
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_SEG = max2(max2(LINE_PIXELS, 8), max2(SETUP_BITS, HOLD_BITS));
    localparam int unsigned BW      = $clog2(MAX_SEG);
    localparam int unsigned PW      = $clog2(CLK_DIV);
    localparam int unsigned GW      = $clog2(CLK_DIV + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REJECT,
        S_SETUP,
        S_MODE,
        S_ADDR,
        S_DATA,
        S_LDUMMY,
        S_TDUMMY,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        OP_STATIC = 2'd0,
        OP_UPDATE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    state_t          state, state_next;
    op_t             op_q;
    logic [PW-1:0]   phase;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   seg_len;
    logic [7:0]      shreg;
    logic [7:0]      shreg_load;
    logic [7:0]      line_addr;
    logic [7:0]      addr_next;
    logic [7:0]      lines_left;
    logic            vcom;
    logic [GW-1:0]   gap_cnt;
    logic [8:0]      last_line;
    logic            cmd_ok;
    logic            idle_ready;
    logic            accept;
    logic            framing;
    logic            serial;
    logic            stall;
    logic            pix_take;
    logic            phase_wrap;
    logic            bit_end;
    logic            last_bit;
    logic            seg_done;

    // ---------------- command qualification ----------------
    assign last_line = {1'b0, cmd_first_line} + {1'b0, cmd_line_count};

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_op)
            2'd0, 2'd2: cmd_ok = 1'b1;
            2'd1: cmd_ok = (cmd_first_line != 8'd0) && (cmd_line_count != 8'd0) &&
                           (last_line <= 9'(NUM_LINES + 1));
            default: cmd_ok = 1'b0;
        endcase
    end

    // cmd_ready waits one bit period after SCS falls so the panel always
    // sees a minimum SCS-low time between frames.
    assign idle_ready = (state == S_IDLE) && (gap_cnt == '0);
    assign accept     = cmd_valid && idle_ready;
    assign cmd_ready  = idle_ready;

    // ---------------- per-segment decode ----------------
    always_comb begin
        seg_len = BW'(8);
        serial  = 1'b0;
        framing = 1'b1;
        case (state)
            S_IDLE, S_REJECT: framing = 1'b0;
            S_SETUP:          seg_len = BW'(SETUP_BITS);
            S_MODE, S_ADDR, S_LDUMMY, S_TDUMMY: serial = 1'b1;
            S_DATA: begin
                serial  = 1'b1;
                seg_len = BW'(LINE_PIXELS);
            end
            S_HOLD:           seg_len = BW'(HOLD_BITS);
            default:          framing = 1'b0;
        endcase
    end

    // ---------------- bit timing ----------------
    // A byte window opens at phase 0 of every eighth DATA bit; the phase
    // counter stays at 0 (SCLK low) until the source supplies the byte.
    assign pix_ready  = (state == S_DATA) && (phase == '0) && (bit_cnt[2:0] == 3'd0);
    assign pix_take   = pix_ready && pix_valid;
    assign stall      = pix_ready && !pix_valid;
    assign phase_wrap = (phase == PW'(CLK_DIV - 1));
    assign bit_end    = framing && phase_wrap;
    assign last_bit   = (bit_cnt == seg_len - 1'b1);
    assign seg_done   = bit_end && last_bit;

    assign SCS  = framing;
    assign SCLK = serial && (phase >= PW'(CLK_DIV / 2));
    // The incoming byte's MSB is forwarded during the handshake cycle so SI
    // is already valid at phase 0 of the first bit of each byte.
    assign SI   = serial && (pix_ready ? pix_data[7] : shreg[7]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        cmd_err    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = cmd_ok ? S_SETUP : S_REJECT;
                end
            end
            S_REJECT: begin
                cmd_err    = 1'b1;
                state_next = S_IDLE;
            end
            S_SETUP:  if (seg_done) state_next = S_MODE;
            S_MODE:   if (seg_done) state_next = (op_q == OP_UPDATE) ? S_ADDR : S_TDUMMY;
            S_ADDR:   if (seg_done) state_next = S_DATA;
            S_DATA:   if (seg_done) state_next = S_LDUMMY;
            S_LDUMMY: if (seg_done) state_next = (lines_left == 8'd1) ? S_TDUMMY : S_ADDR;
            S_TDUMMY: if (seg_done) state_next = S_HOLD;
            S_HOLD:   if (seg_done) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------- shift register reload values ----------------
    always_comb begin
        addr_next  = (state == S_LDUMMY) ? line_addr + 8'd1 : line_addr;
        shreg_load = '0;
        case (state_next)
            S_MODE: shreg_load = {op_q == OP_UPDATE, vcom, op_q == OP_CLEAR, 5'b00000};
            // Address goes out LSB first, so it is loaded bit-reversed.
            S_ADDR: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    shreg_load[7 - i] = addr_next[i];
                end
            end
            default: shreg_load = '0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            op_q       <= OP_STATIC;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            line_addr  <= '0;
            lines_left <= '0;
            vcom       <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (accept) begin
                op_q       <= op_t'(cmd_op);
                line_addr  <= cmd_first_line;
                lines_left <= cmd_line_count;
                phase      <= '0;
                bit_cnt    <= '0;
                shreg      <= '0;
            end
            if (framing) begin
                if (!stall) begin
                    phase <= phase_wrap ? '0 : phase + 1'b1;
                end
                if (pix_take) begin
                    shreg <= pix_data;
                end
                if (bit_end) begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        shreg   <= shreg_load;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                end
                if (seg_done && state == S_LDUMMY) begin
                    line_addr  <= addr_next;
                    lines_left <= lines_left - 8'd1;
                end
                if (seg_done && state == S_HOLD) begin
                    vcom    <= ~vcom;
                    gap_cnt <= GW'(CLK_DIV);
                end
            end
        end
    end

endmodule

// File: tb/tb_sharp_mlcd_line_writer.sv
// tb_sharp_mlcd_line_writer
//   Self-checking bench for sharp_mlcd_line_writer. Expected SI bits are
//   queued when a command is issued and compared at every SCLK rise; frame
//   length, handshake count, ready gap and reject behaviour are checked per
//   command.
module tb_sharp_mlcd_line_writer;

    localparam int CLK_DIV = 12;
    localparam int LP      = 144;
    localparam int NL      = 168;
    localparam int SB      = 8;
    localparam int HB      = 4;
    localparam int BPL     = LP / 8;

    logic       clk_12mhz = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_first_line = 8'd0;
    logic [7:0] cmd_line_count = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] pix_data = 8'd0;
    logic       busy;
    logic       cmd_err;
    logic       SCLK;
    logic       SI;
    logic       SCS;

    sharp_mlcd_line_writer #(
        .CLK_DIV     (CLK_DIV),
        .LINE_PIXELS (LP),
        .NUM_LINES   (NL),
        .SETUP_BITS  (SB),
        .HOLD_BITS   (HB)
    ) dut (
        .clk_12mhz      (clk_12mhz),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_first_line (cmd_first_line),
        .cmd_line_count (cmd_line_count),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .busy           (busy),
        .cmd_err        (cmd_err),
        .SCLK           (SCLK),
        .SI             (SI),
        .SCS            (SCS)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard queues
    bit       exp_q[$];
    bit [7:0] pix_q[$];
    bit       tb_vcom = 1'b0;

    // monitor state
    bit sclk_prev = 1'b0;
    bit scs_prev = 1'b0;
    bit hs_seen = 1'b0;
    bit stall_seen = 1'b0;
    int rises = 0;
    int scs_cnt = 0;
    int scs_len_last = 0;
    int scs_falls = 0;
    int scs_hi_total = 0;
    int hs_cnt = 0;
    int stall_cyc = 0;
    int stall_sclk_hi = 0;
    int err_pulses = 0;

    // pixel source state
    int bytes_given = 0;
    int stall_byte = -1;
    int stall_left = 0;

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_12mhz);
            hs_seen    = pix_valid && pix_ready;
            stall_seen = pix_ready && !pix_valid;
            if (hs_seen) hs_cnt++;
            if (stall_seen) begin
                stall_cyc++;
                if (SCLK) stall_sclk_hi++;
            end
            if (SCLK && !sclk_prev) begin
                rises++;
                check_eq("si_bit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("si_bit", SI, exp_q.pop_front());
                end
            end
            if (SCS) begin
                scs_cnt++;
                scs_hi_total++;
            end else if (scs_prev) begin
                scs_len_last = scs_cnt;
                scs_cnt = 0;
                scs_falls++;
            end
            if (cmd_err) err_pulses++;
            sclk_prev = SCLK;
            scs_prev  = SCS;
        end
    end

    // Pixel source: presents the head of pix_q, pops on a completed handshake,
    // and can withhold valid for 100 ready cycles at a chosen byte.
    initial begin
        forever begin
            @(posedge clk_12mhz);
            #1;
            if (hs_seen && pix_q.size() != 0) begin
                void'(pix_q.pop_front());
                bytes_given++;
            end
            if (bytes_given == stall_byte && stall_left > 0 && stall_seen) stall_left--;
            if (pix_q.size() != 0 && !(bytes_given == stall_byte && stall_left > 0)) begin
                pix_valid = 1'b1;
                pix_data  = pix_q[0];
            end else begin
                pix_valid = 1'b0;
            end
        end
    end

    task automatic prepare_frame(input int op, input int first, input int count, input bit all_ff);
        logic [7:0] av;
        logic [7:0] d;
        exp_q.push_back(op == 1);
        exp_q.push_back(tb_vcom);
        exp_q.push_back(op == 2);
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b0);
        if (op == 1) begin
            for (int l = 0; l < count; l++) begin
                av = 8'(first + l);
                for (int b = 0; b < 8; b++) exp_q.push_back(av[b]);
                for (int k = 0; k < BPL; k++) begin
                    d = all_ff ? 8'hFF : 8'($urandom_range(0, 255));
                    pix_q.push_back(d);
                    for (int b = 7; b >= 0; b--) exp_q.push_back(d[b]);
                end
                for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
            end
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    endtask

    task automatic issue(input int op, input int first, input int count);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk_12mhz);
            #1;
            n++;
        end
        check_eq("cmd_ready_before_issue", cmd_ready, 1);
        cmd_op         = 2'(op);
        cmd_first_line = 8'(first);
        cmd_line_count = 8'(count);
        cmd_valid      = 1'b1;
        @(posedge clk_12mhz);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_frame(input int op, input int first, input int count,
                            input bit all_ff, input int stall_at);
        int exp_len;
        int falls0;
        int hs0;
        int st0;
        int sh0;
        int n;
        prepare_frame(op, first, count, all_ff);
        exp_len = (op == 1) ? CLK_DIV * (SB + 8 + count * (16 + LP) + 8 + HB)
                            : CLK_DIV * (SB + 16 + HB);
        bytes_given = 0;
        stall_byte  = stall_at;
        stall_left  = (stall_at >= 0) ? 100 : 0;
        if (stall_at >= 0) exp_len += 100;
        falls0 = scs_falls;
        hs0    = hs_cnt;
        st0    = stall_cyc;
        sh0    = stall_sclk_hi;
        issue(op, first, count);
        check_eq("busy_after_accept", busy, 1);
        check_eq("ready_after_accept", cmd_ready, 0);
        n = 0;
        while (scs_falls == falls0 && n < 20000) begin
            @(negedge clk_12mhz);
            #1;
            n++;
        end
        check_eq("frame_end_seen", scs_falls != falls0, 1);
        check_eq("scs_window", scs_len_last, exp_len);
        check_eq("busy_after_frame", busy, 0);
        check_eq("pix_handshakes", hs_cnt - hs0, (op == 1) ? count * BPL : 0);
        check_eq("si_bits_left", exp_q.size(), 0);
        check_eq("pix_bytes_left", pix_q.size(), 0);
        if (stall_at >= 0) begin
            check_eq("stall_cycles", stall_cyc - st0, 100);
            check_eq("stall_sclk_high", stall_sclk_hi - sh0, 0);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk_12mhz);
            #1;
            n++;
        end
        check_eq("ready_gap", n, CLK_DIV);
        tb_vcom = ~tb_vcom;
        exp_q.delete();
        pix_q.delete();
    endtask

    task automatic reject_case(input int op, input int first, input int count);
        int e0;
        int s0;
        e0 = err_pulses;
        s0 = scs_hi_total;
        issue(op, first, count);
        check_eq("rej_err_pulse", cmd_err, 1);
        @(posedge clk_12mhz);
        #1;
        check_eq("rej_err_width", cmd_err, 0);
        repeat (3 * CLK_DIV) @(negedge clk_12mhz);
        #1;
        check_eq("rej_scs_quiet", scs_hi_total - s0, 0);
        check_eq("rej_err_count", err_pulses - e0, 1);
        check_eq("rej_ready", cmd_ready, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk_12mhz);
        #1;
        check_eq("rst_scs", SCS, 0);
        check_eq("rst_sclk", SCLK, 0);
        check_eq("rst_si", SI, 0);
        check_eq("rst_pix_ready", pix_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_err", cmd_err, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        exp_q.delete();
        pix_q.delete();
        tb_vcom = 1'b0;
        @(posedge clk_12mhz);
        #1;
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int r0;
        int n;
        repeat (3) @(posedge clk_12mhz);
        #1;
        pulse_reset();

        // 1: single line, all-white bytes
        do_frame(1, 50, 1, 1'b1, -1);

        // 2: back-to-back static frames from a fresh vcom
        pulse_reset();
        do_frame(0, 0, 0, 1'b0, -1);
        do_frame(0, 0, 0, 1'b0, -1);

        // 3: last two lines, then out-of-range and malformed commands
        do_frame(1, 167, 2, 1'b0, -1);
        reject_case(1, 168, 2);
        reject_case(1, 0, 1);
        reject_case(1, 5, 0);
        reject_case(3, 1, 1);

        // 4: source stalls at byte 3
        do_frame(1, 20, 1, 1'b0, 3);

        // 5: all clear
        do_frame(2, 0, 0, 1'b0, -1);

        // 6: reset during line 1, DATA bit 70
        prepare_frame(1, 1, 2, 1'b0);
        bytes_given = 0;
        stall_byte  = -1;
        stall_left  = 0;
        r0 = rises;
        issue(1, 1, 2);
        n = 0;
        while ((rises - r0) < 87 && n < 5000) begin
            @(negedge clk_12mhz);
            #1;
            n++;
        end
        check_eq("reached_data_bit70", rises - r0, 87);
        pulse_reset();
        do_frame(1, 10, 1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout got=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
